wb_stage_ctrl: RTL
==================

// Module: wb_stage_ctrl
// PURPOSE
//  Parametrised writeback-stage controller for the multicycle/pipelined core; successor to the single-opcode WB control.
//  - Fully decodes the WB-stage IR: asserts RF write only for writing opcodes; selects memory vs ALU data; drives write address.
//  - Keeps a per-register scoreboard of in-flight writes, counted from issue to writeback, for hazard detection.
//  - Latches STOP and halts all writeback until reset.
// PARAMETERS
//  IR_W         8  instruction width; opcode = ir[3:0], dest = ir[7:6]
//  NUM_REGS     4  architectural registers
//  REG_AW       2  register address width, clog2(NUM_REGS)
//  MAX_INFLIGHT 3  max outstanding writes per register (1..2**CNT_W-1)
//  CNT_W        2  scoreboard counter width
// PORTS
//  clock      in   1         rising-edge clock
//  reset_n    in   1         asynchronous, active-low reset
//  iss_valid  in   1         instruction issuing this cycle
//  iss_ir     in   IR_W      issuing instruction
//  iss_ready  out  1         comb: 0 if issue would overflow its dest counter, or if halted
//  wb_valid   in   1         instruction present at WB this cycle
//  wb_ir      in   IR_W      WB-stage instruction
//  rf_write   out  1         reg: register-file write enable (the RFWrite role)
//  reg_in     out  1         reg: 1 = memory data (LOAD), 0 = ALU result (the RegIn role)
//  rf_waddr   out  REG_AW    reg: write address
//  busy       out  NUM_REGS  comb: bit r = 1 while count[r] != 0
//  halted     out  1         reg: STOP retired
// BEHAVIOUR
//  - Reset (reset_n low, async): rf_write=0, reg_in=0, rf_waddr=0, halted=0; all counters 0; state RUN.
//    Reset mid-operation drops every pending write.
//  - Decode, shared by issue and WB sides:
//    writes_rf = LOAD 0000, ADD 0100, SUB 0110, NAND 1000, SHIFT x011, ORI x111.
//    No RF write: STORE 0010, BZ 0101, BNZ 1001, BPZ 1101, NOP 1010, STOP 0001, any other code.
//    dest = ir[7:6], except ORI, whose dest is fixed at R1.
//  - Latency: WB instruction sampled at edge t; rf_write/reg_in/rf_waddr valid during cycle t+1 for exactly one cycle.
//    With no writing WB instruction: rf_write=0, reg_in=0, rf_waddr holds its last value.
//  - reg_in=1 only together with rf_write=1 for LOAD.
//  - Scoreboard:
//    Issue accepted (iss_valid & iss_ready & writes_rf): count[dest]++.
//    WB of a writing instruction: count[dest]--.
//    Same register, both events in one cycle: count unchanged.
//    WB with count[dest]==0 is a protocol error: count stays 0 (no wrap); write still performed.
//    iss_ready=0 when count[dest]==MAX_INFLIGHT and no same-cycle WB to that dest. Non-writing ops are always ready unless halted.
//  - FSM:
//    RUN -> HALTED when wb_valid & opcode==STOP. HALTED persists until reset.
//    In HALTED: wb_valid ignored, rf_write=0, iss_ready=0, counters frozen.
//    The STOP edge itself produces no RF write.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: adds output retire_cnt [15:0].
//    Increments on every WB-sampled instruction in RUN, writing or not, including STOP.
//    Wraps 0xFFFF->0; reset to 0.
//  WB_RETIRE_CNT_EN undefined: the port and counter do not exist; all other behaviour identical.
// STRUCTURE
//  - Package wb_ctrl_pkg: opcode localparams (OP_LOAD ... OP_STOP, 4-bit masks for x011/x111), R1 constant,
//    state encoding (ST_RUN, ST_HALTED).
//  - Sub-module wb_decode (combinational: ir -> writes_rf, is_load, is_stop, dest); instantiated twice, issue side and WB side.
//  - Top holds output registers, counter array, FSM.
// TESTING
//  1. Reset low mid-stream with count[2]=2 -> all outputs 0, busy=0000, iss_ready=1 immediately (async).
//  2. WB LOAD ir=8'b10_00_0000 -> next cycle rf_write=1, reg_in=1, rf_waddr=2; following cycle rf_write=0.
//  3. WB STORE 0010, BZ 0101, NOP 1010 -> rf_write stays 0.
//     WB ORI 8'b1111_0111 -> rf_write=1, rf_waddr=1, reg_in=0.
//  4. Issue 3 ADDs to R3 -> busy[3]=1, iss_ready=0 on 4th.
//     4th issue with same-cycle WB to R3 -> accepted, count stays 3.
//     3 WBs -> busy[3]=0.
//  5. WB STOP 0001 followed by WB ADD -> halted=1, no rf_write for either, iss_ready=0 until reset.
//  6. With WB_RETIRE_CNT_EN: 5 WB instructions (mixed) -> retire_cnt=5.
//     Preload 0xFFFF then one WB -> retire_cnt=0.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared opcode encodings, fixed register constants and FSM state type
// for the writeback-stage controller.
package wb_ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    // SHIFT and ORI ignore opcode bit 3, so only the low three bits are matched
    localparam logic [2:0] OP_SHIFT_LO = 3'b011;
    localparam logic [2:0] OP_ORI_LO   = 3'b111;

    localparam int R1 = 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/wb_stage_ctrl_if.sv
// Issue/writeback bus between the pipeline and the WB-stage controller.
// master = pipeline side, slave = controller side.
interface wb_stage_ctrl_if #(
    parameter int IR_W     = 8,
    parameter int REG_AW   = 2,
    parameter int NUM_REGS = 4
);
    logic                iss_valid;
    logic [IR_W-1:0]     iss_ir;
    logic                iss_ready;
    logic                wb_valid;
    logic [IR_W-1:0]     wb_ir;
    logic                rf_write;
    logic                reg_in;
    logic [REG_AW-1:0]   rf_waddr;
    logic [NUM_REGS-1:0] busy;
    logic                halted;

    modport master (
        output iss_valid, iss_ir, wb_valid, wb_ir,
        input  iss_ready, rf_write, reg_in, rf_waddr, busy, halted
    );

    modport slave (
        input  iss_valid, iss_ir, wb_valid, wb_ir,
        output iss_ready, rf_write, reg_in, rf_waddr, busy, halted
    );
endinterface

// File: rtl/wb_decode.sv
// Combinational instruction decode: register-writing class, LOAD/STOP flags
// and destination register. Used on both the issue and writeback sides.
module wb_decode
    import wb_ctrl_pkg::*;
#(
    parameter int IR_W   = 8,
    parameter int REG_AW = 2
) (
    input  logic [IR_W-1:0]   ir,
    output logic              writes_rf,
    output logic              is_load,
    output logic              is_stop,
    output logic [REG_AW-1:0] dest
);
    logic [3:0] op;
    logic       is_ori;
    logic       unused_ir_bits;

    assign op             = ir[3:0];
    assign unused_ir_bits = ^ir;

    always_comb begin
        is_ori    = (op[2:0] == OP_ORI_LO);
        is_load   = (op == OP_LOAD);
        is_stop   = (op == OP_STOP);
        writes_rf = is_load || (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
                    (op[2:0] == OP_SHIFT_LO) || is_ori;
        // ORI always targets R1 regardless of the IR destination field
        dest      = is_ori ? REG_AW'(R1) : ir[IR_W-1 -: REG_AW];
    end
endmodule

// File: rtl/wb_stage_ctrl.sv
// Writeback-stage controller: RF write control, per-register in-flight write
// scoreboard and STOP halt. Define WB_RETIRE_CNT_EN to add the retire_cnt output.
module wb_stage_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int IR_W         = 8,
    parameter int NUM_REGS     = 4,
    parameter int REG_AW       = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    wb_stage_ctrl_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [15:0]      retire_cnt
`endif
);
    logic              iss_writes, iss_is_load, iss_is_stop;
    logic [REG_AW-1:0] iss_dest;
    logic              wb_writes, wb_is_load, wb_is_stop;
    logic [REG_AW-1:0] wb_dest;
    logic              unused_iss_flags;

    wb_decode #(.IR_W(IR_W), .REG_AW(REG_AW)) u_dec_iss (
        .ir        (bus.iss_ir),
        .writes_rf (iss_writes),
        .is_load   (iss_is_load),
        .is_stop   (iss_is_stop),
        .dest      (iss_dest)
    );

    wb_decode #(.IR_W(IR_W), .REG_AW(REG_AW)) u_dec_wb (
        .ir        (bus.wb_ir),
        .writes_rf (wb_writes),
        .is_load   (wb_is_load),
        .is_stop   (wb_is_stop),
        .dest      (wb_dest)
    );

    assign unused_iss_flags = iss_is_load ^ iss_is_stop;

    state_t                           state_q, state_d;
    logic                             rf_write_q, rf_write_d;
    logic                             reg_in_q, reg_in_d;
    logic [REG_AW-1:0]                rf_waddr_q, rf_waddr_d;
    logic [NUM_REGS-1:0][CNT_W-1:0]   cnt_q, cnt_d;

    logic wb_take, wb_wr, same_dest, iss_full, iss_ready, iss_acc;

    // Everything on the WB side is gated by RUN, which also freezes the counters once halted
    assign wb_take   = bus.wb_valid && (state_q == ST_RUN);
    assign wb_wr     = wb_take && wb_writes;
    assign same_dest = wb_wr && (wb_dest == iss_dest);
    assign iss_full  = (cnt_q[iss_dest] == CNT_W'(MAX_INFLIGHT));
    assign iss_ready = (state_q == ST_RUN) && (!iss_writes || !iss_full || same_dest);
    assign iss_acc   = bus.iss_valid && iss_ready && iss_writes;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
        logic inc, dec;
        assign inc = iss_acc && (iss_dest == REG_AW'(gi));
        assign dec = wb_wr && (wb_dest == REG_AW'(gi));
        // A WB against an empty counter is a protocol error: saturate at zero
        assign cnt_d[gi] = (inc && !dec) ? cnt_q[gi] + CNT_W'(1) :
                           (dec && !inc && (cnt_q[gi] != '0)) ? cnt_q[gi] - CNT_W'(1) :
                           cnt_q[gi];
        assign bus.busy[gi] = (cnt_q[gi] != '0);
    end

    always_comb begin
        state_d    = state_q;
        if (wb_take && wb_is_stop) begin
            state_d = ST_HALTED;
        end
        rf_write_d = wb_wr;
        reg_in_d   = wb_wr && wb_is_load;
        rf_waddr_d = wb_wr ? wb_dest : rf_waddr_q;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] retire_q, retire_d;
    assign retire_d   = wb_take ? retire_q + 16'd1 : retire_q;
    assign retire_cnt = retire_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            rf_write_q <= 1'b0;
            reg_in_q   <= 1'b0;
            rf_waddr_q <= '0;
            cnt_q      <= '0;
`ifdef WB_RETIRE_CNT_EN
            retire_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rf_write_q <= rf_write_d;
            reg_in_q   <= reg_in_d;
            rf_waddr_q <= rf_waddr_d;
            cnt_q      <= cnt_d;
`ifdef WB_RETIRE_CNT_EN
            retire_q   <= retire_d;
`endif
        end
    end

    assign bus.iss_ready = iss_ready;
    assign bus.rf_write  = rf_write_q;
    assign bus.reg_in    = reg_in_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.halted    = (state_q == ST_HALTED);
endmodule
